// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int XLEN_DEFAULT   = 32;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6,
        ST_CHK   = 3'd7
    } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// boot_word_assembler: packs a little-endian byte stream into 32-bit words.
// word presents the completed word combinationally on the strobe of the 4th byte.
module boot_word_assembler
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= LANE_B0;
            lanes    <= '0;
        end else if (clear) begin
            byte_idx <= LANE_B0;
        end else if (strobe) begin
            case (byte_idx)
                LANE_B0: lanes[7:0]   <= byte_in;
                LANE_B1: lanes[15:8]  <= byte_in;
                LANE_B2: lanes[23:16] <= byte_in;
                default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign last = (byte_idx == LANE_B3);
    assign word = {byte_in, lanes};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it to instruction memory,
// then releases the core. Define IMEM_BOOT_CHECKSUM_EN to add a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LEN0  | receiving length low byte
// LEN1  | receiving length high byte, range check
// DATA  | receiving instruction bytes
// WRITE | one-cycle write pulse to instruction memory
// DONE  | image loaded, core released
// ERR   | load aborted, core held in reset
// CHK   | receiving checksum byte (checksum build only)
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int XLEN   = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [16:0] LEN_CAP = 17'(1) << ADDR_W;

    boot_state_t       state_q, state_d;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [15:0]       len_full;
    logic              hs;
    logic              start_ok;
    logic              last_word;
    logic              len_over;
    logic              asm_strobe;
    logic              asm_last;
    logic [31:0]       asm_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    assign hs        = rx_valid & rx_ready;
    assign start_ok  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
    assign len_full  = {rx_data, len_q[7:0]};
    assign len_over  = {1'b0, len_full} > LEN_CAP;
    assign cnt_inc   = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word = (17'(cnt_inc) == {1'b0, len_q});

    boot_word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .strobe  (asm_strobe),
        .clear   (start_ok),
        .byte_in (rx_data),
        .word    (asm_word),
        .last    (asm_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rx_ready   = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_run   = 1'b0;
        asm_strobe = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN0;
            end
            ST_LEN0: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (hs) state_d = ST_LEN1;
            end
            ST_LEN1: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (hs) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else if (len_over) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                rx_ready   = 1'b1;
                busy       = 1'b1;
                asm_strobe = hs;
                if (hs && asm_last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
                if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                core_run = 1'b1;
                if (start) state_d = ST_LEN0;
            end
            ST_ERR: begin
                err = 1'b1;
                if (start) state_d = ST_LEN0;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK: begin
                rx_ready = 1'b1;
                if (hs) state_d = (rx_data == xor_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Address and data are captured with the 4th byte so they stay put outside WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            if (state_q == ST_LEN0 && hs) len_q[7:0]  <= rx_data;
            if (state_q == ST_LEN1 && hs) len_q[15:8] <= rx_data;
            if (start_ok) begin
                word_cnt_q <= '0;
            end else if (state_q == ST_WRITE) begin
                word_cnt_q <= cnt_inc;
            end
            if (asm_strobe && asm_last) begin
                waddr_q <= word_cnt_q[ADDR_W-1:0];
                wdata_q <= asm_word;
            end
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q <= '0;
        end else if (start_ok) begin
            xor_q <= '0;
        end else if (asm_strobe) begin
            xor_q <= xor_q ^ rx_data;
        end
    end
`endif

    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader; expected writes are queued as bytes are driven.
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              core_run;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_cnt;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [41:0] sb_q[$];
    logic [31:0] img [0:1023];

    imem_boot_loader #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .core_run (core_run),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [41:0] e;
        if (!rst && we) begin
            if (sb_q.size() == 0) begin
                chk("we_unexpected", 64'(we), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("waddr", 64'(waddr), 64'(e[41:32]));
                chk("wdata", 64'(wdata), 64'(e[31:0]));
            end
            chk("rx_ready_in_write", 64'(rx_ready), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        start    = 1'b0;
        sb_q.delete();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic send(input logic [7:0] b, input bit bp);
        bit ok;
        ok = 1'b0;
        if (bp && $urandom_range(0, 1) == 1) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                step();
            end
        end
        if (!ok) chk("hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic load(input int n, input bit bp, input bit bad_ck);
        logic [7:0]  byt;
        logic [7:0]  xr;
        logic [15:0] nl;
        logic [31:0] wv;
        bit          exp_ok;
        nl = n[15:0];
        xr = 8'h00;
        pulse_start();
        chk("busy_len0", 64'(busy), 64'd1);
        chk("core_run_len0", 64'(core_run), 64'd0);
        send(nl[7:0], bp);
        send(nl[15:8], bp);
        for (int w = 0; w < n; w++) begin
            wv = img[w];
            sb_q.push_back({w[9:0], wv});
            for (int k = 0; k < 4; k++) begin
                byt = wv[8*k +: 8];
                xr  = xr ^ byt;
                send(byt, bp);
            end
            chk("we_after_4th", 64'(we), 64'd1);
            step();
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        send(bad_ck ? ~xr : xr, bp);
        exp_ok = !bad_ck;
`else
        exp_ok = 1'b1;
`endif
        rx_valid = 1'b0;
        chk("done", 64'(done), 64'(exp_ok));
        chk("err", 64'(err), 64'(!exp_ok));
        chk("core_run", 64'(core_run), 64'(exp_ok));
        chk("busy_end", 64'(busy), 64'd0);
        chk("rx_ready_end", 64'(rx_ready), 64'd0);
        chk("word_cnt", 64'(word_cnt), 64'(n));
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        img[0] = 32'hFFC4A303;
        img[1] = 32'h00832383;
        do_reset();
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_core_run", 64'(core_run), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);

        // two-word image with rx_valid held high
        load(2, 1'b0, 1'b0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        load(2, 1'b0, 1'b1);
`endif

        // empty image
        load(0, 1'b0, 1'b0);

        // oversize length 1025
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h04, 1'b0);
        rx_valid = 1'b0;
        chk("ovr_err", 64'(err), 64'd1);
        chk("ovr_core_run", 64'(core_run), 64'd0);
        chk("ovr_rx_ready", 64'(rx_ready), 64'd0);
        chk("ovr_done", 64'(done), 64'd0);
        chk("ovr_busy", 64'(busy), 64'd0);
        pulse_start();
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_rx_ready", 64'(rx_ready), 64'd1);
        chk("restart_err", 64'(err), 64'd0);
        do_reset();

        // backpressure
        load(2, 1'b1, 1'b0);

        // reset mid-load, after one word and two bytes of the next
        pulse_start();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        sb_q.push_back({10'd0, 32'hFFC4A303});
        send(8'h03, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hC4, 1'b0);
        send(8'hFF, 1'b0);
        step();
        send(8'h83, 1'b0);
        send(8'h23, 1'b0);
        chk("pre_rst_wdata", 64'(wdata), 64'hFFC4A303);
        rst = 1'b1;
        #1;
        chk("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_we", 64'(we), 64'd0);
        chk("mid_rst_wdata", 64'(wdata), 64'd0);
        chk("mid_rst_waddr", 64'(waddr), 64'd0);
        chk("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("mid_rst_core_run", 64'(core_run), 64'd0);
        chk("mid_rst_sb_empty", 64'(sb_q.size()), 64'd0);
        rx_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        load(2, 1'b0, 1'b0);

        // full-capacity image
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        load(1024, 1'b0, 1'b0);
        chk("last_waddr", 64'(waddr), 64'd1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
